// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Purpose  : Matrix-keypad scanner with per-key debounce and a key-event FIFO.
//            Define KEY_RELEASE_EVT_EN to also queue key-release events.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 16,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    localparam int CODE_W        = $clog2(ROWS*COLS),
    localparam int CNT_W         = $clog2(FIFO_DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [COLS-1:0]   col,
    input  logic [ROWS-1:0]   fil,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam int c_keys    = ROWS * COLS;
    localparam int c_deb_w   = $clog2(DEBOUNCE_SCANS + 1);
    localparam int c_dwell_w = $clog2(SCAN_DIV);
    localparam int c_col_w   = $clog2(COLS);
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
`ifdef KEY_RELEASE_EVT_EN
    localparam int c_entry_w = CODE_W + 1;
`else
    localparam int c_entry_w = CODE_W;
`endif

    // ---------------------------------------------------------------- scan
    logic [c_dwell_w-1:0] r_dwell;
    logic [c_col_w-1:0]   r_col_idx;
    logic                 w_sample;

    assign w_sample = (r_dwell == c_dwell_w'(SCAN_DIV - 1));
    assign col      = {{(COLS-1){1'b0}}, 1'b1} << r_col_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dwell   <= '0;
            r_col_idx <= '0;
        end else if (w_sample) begin
            r_dwell   <= '0;
            r_col_idx <= (r_col_idx == c_col_w'(COLS - 1)) ? '0 : r_col_idx + 1'b1;
        end else begin
            r_dwell   <= r_dwell + 1'b1;
        end
    end

    // ------------------------------------------------------------ debounce
    logic [c_keys-1:0]              r_key_state, w_key_state_nxt;
    logic [c_keys-1:0][c_deb_w-1:0] r_deb_cnt, w_deb_cnt_nxt;
    logic [CODE_W-1:0]              w_idx;
    logic                           w_commit;
    logic                           w_evt_valid, r_evt_valid;
    logic [CODE_W-1:0]              w_evt_code, r_evt_code;
`ifdef KEY_RELEASE_EVT_EN
    logic                           w_evt_rel, r_evt_rel;
`endif

    always_comb begin
        w_key_state_nxt = r_key_state;
        w_deb_cnt_nxt   = r_deb_cnt;
        w_idx           = '0;
        w_commit        = 1'b0;
        w_evt_valid     = 1'b0;
        w_evt_code      = '0;
`ifdef KEY_RELEASE_EVT_EN
        w_evt_rel       = 1'b0;
`endif
        if (w_sample) begin
            for (int r = 0; r < ROWS; r++) begin
                w_idx = CODE_W'(r * COLS) + CODE_W'(r_col_idx);
                if (fil[r] == r_key_state[w_idx]) begin
                    w_deb_cnt_nxt[w_idx] = '0;
                end else if (!w_commit &&
                             (r_deb_cnt[w_idx] >= c_deb_w'(DEBOUNCE_SCANS - 1))) begin
                    // Lowest pending row commits; higher pending rows stay saturated
                    w_commit               = 1'b1;
                    w_key_state_nxt[w_idx] = fil[r];
                    w_deb_cnt_nxt[w_idx]   = '0;
                    w_evt_code             = w_idx;
`ifdef KEY_RELEASE_EVT_EN
                    w_evt_valid            = 1'b1;
                    w_evt_rel              = ~fil[r];
`else
                    w_evt_valid            = fil[r];
`endif
                end else if (r_deb_cnt[w_idx] != c_deb_w'(DEBOUNCE_SCANS)) begin
                    w_deb_cnt_nxt[w_idx] = r_deb_cnt[w_idx] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_state <= '0;
            r_deb_cnt   <= '0;
            r_evt_valid <= 1'b0;
            r_evt_code  <= '0;
`ifdef KEY_RELEASE_EVT_EN
            r_evt_rel   <= 1'b0;
`endif
        end else begin
            r_key_state <= w_key_state_nxt;
            r_deb_cnt   <= w_deb_cnt_nxt;
            r_evt_valid <= w_evt_valid;
            r_evt_code  <= w_evt_code;
`ifdef KEY_RELEASE_EVT_EN
            r_evt_rel   <= w_evt_rel;
`endif
        end
    end

    // ---------------------------------------------------------------- fifo
    logic [c_entry_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_overflow;
    logic [c_entry_w-1:0] w_wr_entry, w_head;
    logic                 w_full, w_pop, w_push, w_drop;

`ifdef KEY_RELEASE_EVT_EN
    assign w_wr_entry  = {r_evt_rel, r_evt_code};
`else
    assign w_wr_entry  = r_evt_code;
`endif
    assign w_head      = r_mem[r_rd_ptr];
    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign key_valid   = (r_count != '0);
    assign w_pop       = key_valid & key_ready;
    // A pop in the same cycle frees the slot a full-FIFO push needs
    assign w_push      = r_evt_valid & (~w_full | w_pop);
    assign w_drop      = r_evt_valid & w_full & ~w_pop;

    assign key_code    = key_valid ? w_head[CODE_W-1:0] : '0;
`ifdef KEY_RELEASE_EVT_EN
    assign key_release = key_valid & w_head[CODE_W];
`else
    assign key_release = 1'b0;
`endif
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_fifo
// Purpose  : Directed bench for keypad_scan_fifo with a physical keypad model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] col;
    logic [3:0] fil;
    logic [3:0] key_code;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       overflow_clr;

    logic [3:0][3:0] pad;   // pad[row][column]: 1 = key held down

    int n_checks = 0;
    int n_fail   = 0;

    keypad_scan_fifo dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col          (col),
        .fil          (fil),
        .key_code     (key_code),
        .key_release  (key_release),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    always_comb begin
        fil = '0;
        for (int r = 0; r < 4; r++) begin
            fil[r] = |(pad[r] & col);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual running required finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         cyc;
        logic [3:0] exp_col;
    } scan_vec_t;

    typedef struct {
        int         row;
        int         cl;
        logic [2:0] exp_count;
        logic       exp_ovf;
    } press_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        pad          = '0;
        key_ready    = 1'b0;
        overflow_clr = 1'b0;
        step(2);
        rst_n        = 1'b1;
    endtask

    task automatic pop();
        key_ready = 1'b1;
        step(1);
        key_ready = 1'b0;
    endtask

    // Returns on the negedge just after column c was sampled
    task automatic wait_col_leave(input int c, input string name);
        logic [3:0] prev;
        logic [3:0] oh;
        bit         done;
        oh   = 4'b0001 << c;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            prev = col;
            step(1);
            if (prev == oh && col != prev) done = 1'b1;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_state(input logic [2:0] cnt, input logic ovf, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            step(1);
            if (fifo_count == cnt && overflow == ovf) hit = 1'b1;
        end
        check(name, 32'(hit), 32'd1);
    endtask

    initial begin
        scan_vec_t  scan_tbl [9];
        press_vec_t press_tbl [5];
        logic [3:0] pop_codes [4];
        bit         onehot_ok;
        bit         quiet;
        int         k;

        scan_tbl[0] = '{1,  4'b0001};
        scan_tbl[1] = '{15, 4'b0001};
        scan_tbl[2] = '{16, 4'b0010};
        scan_tbl[3] = '{31, 4'b0010};
        scan_tbl[4] = '{32, 4'b0100};
        scan_tbl[5] = '{47, 4'b0100};
        scan_tbl[6] = '{48, 4'b1000};
        scan_tbl[7] = '{63, 4'b1000};
        scan_tbl[8] = '{64, 4'b0001};

        press_tbl[0] = '{0, 0, 3'd1, 1'b0};   // code 0
        press_tbl[1] = '{1, 2, 3'd2, 1'b0};   // code 6
        press_tbl[2] = '{2, 3, 3'd3, 1'b0};   // code 11
        press_tbl[3] = '{3, 1, 3'd4, 1'b0};   // code 13
        press_tbl[4] = '{0, 3, 3'd4, 1'b1};   // code 3, dropped

        pop_codes[0] = 4'd6;
        pop_codes[1] = 4'd11;
        pop_codes[2] = 4'd13;
        pop_codes[3] = 4'd14;

        pad          = '0;
        key_ready    = 1'b0;
        overflow_clr = 1'b0;

        // ---- reset values
        #1 rst_n = 1'b0;
        #2;
        check("rst_col",      32'(col),         32'h1);
        check("rst_valid",    32'(key_valid),   32'h0);
        check("rst_count",    32'(fifo_count),  32'h0);
        check("rst_code",     32'(key_code),    32'h0);
        check("rst_release",  32'(key_release), 32'h0);
        check("rst_overflow", 32'(overflow),    32'h0);
        step(2);
        rst_n = 1'b1;

        // ---- free-running scan with no keys
        onehot_ok = 1'b1;
        quiet     = 1'b1;
        k         = 0;
        for (int cyc = 1; cyc <= 64; cyc++) begin
            step(1);
            if ($countones(col) != 1) onehot_ok = 1'b0;
            if (key_valid) quiet = 1'b0;
            if (k < 9 && cyc == scan_tbl[k].cyc) begin
                check($sformatf("scan_col_c%0d", cyc), 32'(col), 32'(scan_tbl[k].exp_col));
                k++;
            end
        end
        check("scan_onehot", 32'(onehot_ok), 32'd1);
        check("scan_quiet",  32'(quiet),     32'd1);

        // ---- single key 10, exact latency, pop, empty pop ignored
        apply_reset();
        pad[2][2] = 1'b1;
        step(176);
        check("k10_valid_before", 32'(key_valid), 32'd0);
        step(1);
        check("k10_valid",   32'(key_valid),  32'd1);
        check("k10_code",    32'(key_code),   32'd10);
        check("k10_count",   32'(fifo_count), 32'd1);
        step(64);
        check("k10_single",  32'(fifo_count), 32'd1);
        pop();
        check("k10_popped",  32'(fifo_count), 32'd0);
        check("k10_empty",   32'(key_valid),  32'd0);
        key_ready = 1'b1;
        step(3);
        key_ready = 1'b0;
        check("empty_pop_ignored", 32'(fifo_count), 32'd0);

        // ---- glitch on key 5 for one visit
        apply_reset();
        wait_col_leave(1, "glitch_sync");
        pad[1][1] = 1'b1;
        wait_col_leave(1, "glitch_visit");
        pad[1][1] = 1'b0;
        check("glitch_cnt_one",  32'(dut.r_deb_cnt[5]), 32'd1);
        wait_col_leave(1, "glitch_after");
        check("glitch_cnt_zero", 32'(dut.r_deb_cnt[5]), 32'd0);
        step(200);
        check("glitch_no_event", 32'(fifo_count), 32'd0);

        // ---- keys 5 and 9 together, then async reset mid-dwell
        apply_reset();
        pad[1][1] = 1'b1;
        pad[2][1] = 1'b1;
        step(160);
        check("dual_none_yet", 32'(fifo_count), 32'd0);
        step(1);
        check("dual_first_cnt",  32'(fifo_count), 32'd1);
        check("dual_first_code", 32'(key_code),   32'd5);
        step(63);
        check("dual_gap",        32'(fifo_count), 32'd1);
        step(1);
        check("dual_second_cnt", 32'(fifo_count), 32'd2);
        pop();
        check("dual_second_code", 32'(key_code),  32'd9);
        #3 rst_n = 1'b0;
        #1;
        check("async_col",   32'(col),        32'h1);
        check("async_count", 32'(fifo_count), 32'd0);
        check("async_valid", 32'(key_valid),  32'd0);
        step(2);
        rst_n = 1'b1;
        step(160);
        check("held_no_early", 32'(fifo_count), 32'd0);
        step(1);
        check("held_redetect", 32'(fifo_count), 32'd1);
        check("held_code",     32'(key_code),   32'd5);

        // ---- fill, overflow, clear, set-wins, full push with pop
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            pad[press_tbl[i].row][press_tbl[i].cl] = 1'b1;
            wait_state(press_tbl[i].exp_count, press_tbl[i].exp_ovf, $sformatf("fill_wait_%0d", i));
            step(70);
            check($sformatf("fill_count_%0d", i), 32'(fifo_count), 32'(press_tbl[i].exp_count));
            check($sformatf("fill_ovf_%0d", i),   32'(overflow),   32'(press_tbl[i].exp_ovf));
        end
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        pad[1][0]    = 1'b1;
        overflow_clr = 1'b1;
        wait_state(3'd4, 1'b1, "ovf_set_wins");
        overflow_clr = 1'b0;
        step(2);
        check("ovf_sticky", 32'(overflow),   32'd1);
        check("ovf_count",  32'(fifo_count), 32'd4);
        overflow_clr = 1'b1;
        step(1);
        overflow_clr = 1'b0;
        check("ovf_cleared2", 32'(overflow), 32'd0);
        check("head_a",       32'(key_code), 32'd0);
        wait_col_leave(2, "fullpop_sync");
        pad[3][2] = 1'b1;
        repeat (3) wait_col_leave(2, "fullpop_visit");
        pop();
        check("fullpop_count", 32'(fifo_count), 32'd4);
        check("fullpop_ovf",   32'(overflow),   32'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_code_%0d", i), 32'(key_code), 32'(pop_codes[i]));
            pop();
        end
        check("drain_empty", 32'(key_valid), 32'd0);

`ifdef KEY_RELEASE_EVT_EN
        // ---- press then release of key 0
        apply_reset();
        pad[0][0] = 1'b1;
        wait_state(3'd1, 1'b0, "rel_press_wait");
        pad[0][0] = 1'b0;
        wait_state(3'd2, 1'b0, "rel_release_wait");
        check("rel_first_code", 32'(key_code),    32'd0);
        check("rel_first_flag", 32'(key_release), 32'd0);
        pop();
        check("rel_second_code", 32'(key_code),    32'd0);
        check("rel_second_flag", 32'(key_release), 32'd1);
        pop();
        check("rel_empty", 32'(key_valid), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/keypad_scan_fifo.md
Name: keypad_scan_fifo

Overview:
Parametrised matrix-keypad reader, successor to the single-key latch reader. Drives a one-hot column scan over COLS columns and samples ROWS row inputs. Debounces every key independently and encodes each press as a linear key code. Buffers codes in a FIFO drained through a valid/ready handshake, so multi-key typing is not lost between consumer reads.

Parameters:
ROWS, 4, number of row inputs (2..8)
COLS, 4, number of scanned columns (2..8)
SCAN_DIV, 16, clk cycles each column stays active (>=2)
DEBOUNCE_SCANS, 3, consecutive disagreeing visits needed to commit a key change (1..15)
FIFO_DEPTH, 4, key-event FIFO entries (power of 2, >=2)
Derived: CODE_W = $clog2(ROWS*COLS); CNT_W = $clog2(FIFO_DEPTH+1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
col  out  COLS  one-hot active-high column drive
fil  in  ROWS  row sense, 1 = key closed in active column
key_code  out  CODE_W  FIFO head: row*COLS + column
key_release  out  1  head event type (only with KEY_RELEASE_EVT_EN; else tied 0)
key_valid  out  1  FIFO not empty
key_ready  in  1  consumer pop; pop occurs when key_valid & key_ready at clk edge
fifo_count  out  CNT_W  entries held
overflow  out  1  sticky: an event was dropped
overflow_clr  in  1  clears overflow

Behaviour:
- Reset (async assert, sync release): col = 1 (column 0), dwell counter 0, all key states released, all debounce counters 0, FIFO empty, key_valid 0, key_code 0, key_release 0, fifo_count 0, overflow 0.
- Scan: col[c] held SCAN_DIV cycles, then advances to c+1; wraps COLS-1 -> 0. The one-hot invariant holds every cycle.
- Sample: fil is sampled on the last dwell cycle (dwell counter = SCAN_DIV-1) to allow settling. Only keys of the active column are updated.
- Per-key debounce: sample equal to committed state -> counter cleared. Sample differs -> counter increments, saturating at DEBOUNCE_SCANS. At DEBOUNCE_SCANS the key is pending.
- Commit: per sample, at most one pending key commits: the lowest row index in the active column. It toggles state, clears its counter and generates an event. Other pending keys stay saturated and commit on later visits, so no event is lost.
- Event generation: press events always; release events only with the macro. The FIFO write occurs on the clk edge following the sample edge. key_valid is high from that edge onward.
- FIFO: head shown combinationally on key_code/key_release.
  - Push when full with no pop in the same cycle -> event dropped, overflow <= 1.
  - Full with a simultaneous pop -> push accepted, count unchanged.
  - Empty with a push -> count becomes 1; a pop is impossible that cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- key_ready while key_valid = 0 is ignored.
- overflow_clr and a new drop in the same cycle -> overflow stays 1 (set wins).
- Reset mid-scan or mid-debounce -> everything returns to reset values immediately. A key held through reset is re-detected as a press after DEBOUNCE_SCANS visits.

Optional Feature:
KEY_RELEASE_EVT_EN
- Defined: committed 1->0 transitions also push an event with key_release = 1; presses push with key_release = 0. Each FIFO entry is CODE_W+1 bits wide.
- Undefined: release commits update key state silently. key_release is tied 0 and FIFO entries are CODE_W bits wide.

Test Plan:
1. Reset then free-run, default params -> col sequence 0001, 0010, 0100, 1000, 0001, each held 16 cycles. key_valid = 0 throughout with fil = 0.
2. Hold fil[2] high only while col = 0100 for 3 full scan rounds -> exactly one entry with key_code = 10 (2*4+2). key_valid rises 1 cycle after the 3rd sampling edge. A pop with key_ready empties the FIFO and fifo_count returns to 0.
3. fil[1] glitches high during one visit only (DEBOUNCE_SCANS = 3) -> no event, and the counter for that key is back to 0 after the next low sample.
4. Keys 5 and 9 in the same column (rows 1 and 2) pressed simultaneously -> code 5 is pushed first and code 9 one scan round later; fifo_count = 2.
5. key_ready held 0, 5 distinct presses with FIFO_DEPTH = 4 -> fifo_count = 4, overflow = 1, and the 5th code is absent from pops. overflow_clr drops overflow to 0.
6. With KEY_RELEASE_EVT_EN: press then release key 0 -> two entries, (0, release = 0) then (0, release = 1). Asserting rst_n = 0 mid-dwell clears the FIFO and sets col = 0001 asynchronously.
